// File: rtl/cic3_row_readout_sequencer.sv
// cic3_row_readout_sequencer: snapshots the CIC3 row on each decimated strobe and drains enabled channels onto one valid/ready stream.
module cic3_row_readout_sequencer #(
  parameter int NUM_CHANNELS = 24,
  parameter int DATA_WIDTH   = 25,
  parameter int CHAN_W       = 5,
  parameter int FRAME_W      = 8,
  parameter int OVR_W        = 8
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] filter_out_i,
  input  logic                               sample_strobe_i,
  input  logic [NUM_CHANNELS-1:0]            chan_enable_i,
  input  logic                               clear_status_i,
  output logic [DATA_WIDTH-1:0]              dout_data_o,
  output logic [CHAN_W-1:0]                  dout_chan_o,
  output logic [FRAME_W-1:0]                 dout_frame_o,
  output logic                               dout_last_o,
  output logic                               dout_valid_o,
  input  logic                               dout_ready_i,
  output logic                               busy_o,
  output logic                               overrun_flag_o,
  output logic [OVR_W-1:0]                   overrun_cnt_o
);
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t                            state_q, state_d;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic [NUM_CHANNELS-1:0]           mask_q, mask_d;
  logic [CHAN_W-1:0]                 cur_q, cur_d, first_en, next_en;
  logic [FRAME_W-1:0]                frame_q, frame_d, fcnt_q, fcnt_d;
  logic                              ovr_flag_q, ovr_flag_d;
  logic [OVR_W-1:0]                  ovr_cnt_q, ovr_cnt_d;
  logic                              has_next, drain, hs, last_hs, accept, drop;
  // Lowest set bit of the live enables, and lowest latched channel above the cursor.
  always_comb begin
    first_en = '0;
    next_en  = '0;
    has_next = 1'b0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (chan_enable_i[i]) first_en = CHAN_W'(i);
      if (mask_q[i] && CHAN_W'(i) > cur_q) begin
        next_en  = CHAN_W'(i);
        has_next = 1'b1;
      end
    end
  end
  assign drain   = state_q == DRAIN;
  assign hs      = drain & dout_ready_i;
  assign last_hs = hs & ~has_next;
  // A strobe landing on the final handshake chains straight into the next frame.
  assign accept  = sample_strobe_i & |chan_enable_i & (~drain | last_hs);
  assign drop    = sample_strobe_i & drain & ~last_hs;
  always_comb begin
    state_d    = accept ? DRAIN : (last_hs ? IDLE : state_q);
    shadow_d   = accept ? filter_out_i : shadow_q;
    mask_d     = accept ? chan_enable_i : mask_q;
    cur_d      = accept ? first_en : ((hs && has_next) ? next_en : cur_q);
    frame_d    = accept ? fcnt_q : frame_q;
    fcnt_d     = accept ? fcnt_q + FRAME_W'(1) : fcnt_q;
    ovr_flag_d = clear_status_i ? 1'b0 : (ovr_flag_q | drop);
    ovr_cnt_d  = clear_status_i ? '0 : ((drop && !(&ovr_cnt_q)) ? ovr_cnt_q + OVR_W'(1) : ovr_cnt_q);
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      mask_q     <= '0;
      cur_q      <= '0;
      frame_q    <= '0;
      fcnt_q     <= '0;
      ovr_flag_q <= 1'b0;
      ovr_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      mask_q     <= mask_d;
      cur_q      <= cur_d;
      frame_q    <= frame_d;
      fcnt_q     <= fcnt_d;
      ovr_flag_q <= ovr_flag_d;
      ovr_cnt_q  <= ovr_cnt_d;
    end
  end
  assign dout_data_o    = shadow_q[cur_q*DATA_WIDTH +: DATA_WIDTH];
  assign dout_chan_o    = cur_q;
  assign dout_frame_o   = frame_q;
  assign dout_last_o    = drain & ~has_next;
  assign dout_valid_o   = drain;
  assign busy_o         = drain;
  assign overrun_flag_o = ovr_flag_q;
  assign overrun_cnt_o  = ovr_cnt_q;
endmodule

// File: tb/tb_cic3_row_readout_sequencer.sv
// tb_cic3_row_readout_sequencer: queue-of-expected-words reference model plus directed tables for the readout sequencer.
module tb_cic3_row_readout_sequencer;
  logic         clk = 1'b0;
  logic         rst, stb, clr, rdy;
  logic [23:0]  en;
  logic [599:0] filter_out;
  logic [24:0]  filt [24];
  logic [24:0]  dout_data;
  logic [4:0]   dout_chan;
  logic [7:0]   dout_frame, ovr_cnt;
  logic         dout_last, dout_valid, busy, ovr_flag;
  int           n_vec = 0, n_bad = 0;
  typedef struct {logic [24:0] d; logic [4:0] c; logic [7:0] f; logic l;} word_t;
  typedef struct {logic [23:0] en; int first; int last_ch; int cnt;} vec_t;
  word_t        q [$];
  logic [7:0]   m_fcnt;
  logic         m_ovf;
  int           m_ovc;
  vec_t         tbl [7];
  always #5 clk = ~clk;
  always_comb for (int k = 0; k < 24; k++) filter_out[k*25 +: 25] = filt[k];
  cic3_row_readout_sequencer dut (
    .clk_i(clk), .reset_i(rst), .filter_out_i(filter_out), .sample_strobe_i(stb),
    .chan_enable_i(en), .clear_status_i(clr), .dout_data_o(dout_data), .dout_chan_o(dout_chan),
    .dout_frame_o(dout_frame), .dout_last_o(dout_last), .dout_valid_o(dout_valid),
    .dout_ready_i(rdy), .busy_o(busy), .overrun_flag_o(ovr_flag), .overrun_cnt_o(ovr_cnt));
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    q.delete();
    m_fcnt = 0;
    m_ovf = 0;
    m_ovc = 0;
  endtask
  // Check current outputs against the model, then advance the model by the inputs now applied.
  task automatic tick();
    int sz;
    bit h, lh, dropped;
    int hi;
    sz = q.size();
    chk("valid", dout_valid, sz != 0);
    chk("busy", busy, sz != 0);
    if (sz != 0) begin
      chk("data", dout_data, q[0].d);
      chk("chan", dout_chan, q[0].c);
      chk("frame", dout_frame, q[0].f);
      chk("last", dout_last, q[0].l);
    end
    chk("ovr_flag", ovr_flag, m_ovf);
    chk("ovr_cnt", ovr_cnt, m_ovc);
    h = sz > 0 && rdy;
    lh = h && sz == 1;
    dropped = 0;
    if (h) void'(q.pop_front());
    if (stb) begin
      if (sz == 0 || lh) begin
        if (en != 0) begin
          hi = 0;
          for (int k = 0; k < 24; k++) if (en[k]) hi = k;
          for (int k = 0; k < 24; k++)
            if (en[k]) q.push_back('{d: filt[k], c: 5'(k), f: m_fcnt, l: k == hi});
          m_fcnt++;
        end
      end else dropped = 1;
    end
    if (clr) begin
      m_ovf = 0;
      m_ovc = 0;
    end else if (dropped) begin
      m_ovf = 1;
      if (m_ovc < 255) m_ovc++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", dout_data, 0);
    chk("rst_chan", dout_chan, 0);
    chk("rst_last", dout_last, 0);
    chk("rst_frame", dout_frame, 0);
    chk("rst_ovf", ovr_flag, 0);
    chk("rst_ovc", ovr_cnt, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic drain_all();
    stb = 0;
    rdy = 1;
    for (int i = 0; i < 40 && q.size() > 0; i++) tick();
    chk("drained", q.size(), 0);
  endtask
  initial begin
    rst = 1; stb = 0; clr = 0; rdy = 1; en = '1;
    for (int k = 0; k < 24; k++) filt[k] = 25'(k * 1000);
    model_reset();
    @(negedge clk);
    do_reset();
    // All channels, data k*1000, strobe in cycle 10
    for (int i = 0; i < 9; i++) tick();
    stb = 1;
    tick();
    stb = 0;
    chk("first_chan", dout_chan, 0);
    chk("first_frame", dout_frame, 0);
    for (int i = 0; i < 23; i++) tick();
    chk("chan23_data", dout_data, 23000);
    chk("chan23_last", dout_last, 1);
    tick();
    chk("busy_after", busy, 0);
    // Enable-mask table
    tbl[0] = '{24'h000801, 0, 11, 2};
    tbl[1] = '{24'hFFFFFF, 0, 23, 24};
    tbl[2] = '{24'h800000, 23, 23, 1};
    tbl[3] = '{24'h000001, 0, 0, 1};
    tbl[4] = '{24'h555555, 0, 22, 12};
    tbl[5] = '{24'hAAAAAA, 1, 23, 12};
    tbl[6] = '{24'hF00000, 20, 23, 4};
    for (int t = 0; t < 7; t++) begin
      int cnt, fc, lc;
      cnt = 0; fc = -1; lc = -1;
      for (int k = 0; k < 24; k++) filt[k] = 25'($urandom);
      en = tbl[t].en;
      stb = 1;
      rdy = 1;
      tick();
      stb = 0;
      for (int i = 0; i < 30 && dout_valid; i++) begin
        if (cnt == 0) fc = int'(dout_chan);
        if (dout_last) lc = int'(dout_chan);
        cnt++;
        tick();
      end
      chk("tbl_first", fc, tbl[t].first);
      chk("tbl_last", lc, tbl[t].last_ch);
      chk("tbl_cnt", cnt, tbl[t].cnt);
    end
    // Stall pattern 1,0,0,1
    en = 24'h000FFF;
    stb = 1;
    tick();
    stb = 0;
    for (int i = 0; i < 100 && q.size() > 0; i++) begin
      rdy = (i % 4 == 0) || (i % 4 == 3);
      tick();
    end
    chk("stall_drained", q.size(), 0);
    rdy = 1;
    // Overrun mid-drain, then chained strobe on last handshake
    do_reset();
    en = 24'h00000F;
    stb = 1;
    tick();
    stb = 0;
    tick();
    stb = 1;
    tick();
    stb = 0;
    chk("ovr_flag_set", ovr_flag, 1);
    chk("ovr_cnt_one", ovr_cnt, 1);
    for (int i = 0; i < 40 && q.size() > 1; i++) tick();
    chk("reach_last", q.size(), 1);
    stb = 1;
    tick();
    stb = 0;
    chk("chain_valid", dout_valid, 1);
    chk("chain_frame", dout_frame, 1);
    chk("chain_chan", dout_chan, 0);
    chk("chain_ovc", ovr_cnt, 1);
    drain_all();
    // Saturation then clear colliding with an overrun
    en = '1;
    rdy = 0;
    stb = 1;
    tick();
    for (int i = 0; i < 300; i++) tick();
    chk("sat_cnt", ovr_cnt, 255);
    clr = 1;
    tick();
    clr = 0;
    stb = 0;
    chk("clr_cnt", ovr_cnt, 0);
    chk("clr_flag", ovr_flag, 0);
    drain_all();
    // Reset mid-drain, then an all-disabled strobe
    en = '1;
    stb = 1;
    tick();
    stb = 0;
    for (int i = 0; i < 4; i++) tick();
    do_reset();
    en = '0;
    stb = 1;
    tick();
    stb = 0;
    chk("ign_busy", busy, 0);
    tick();
    en = 24'h000100;
    stb = 1;
    tick();
    stb = 0;
    chk("post_rst_frame", dout_frame, 0);
    chk("post_rst_chan", dout_chan, 8);
    drain_all();
    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 24; k++) filt[k] = 25'($urandom);
      case ($urandom_range(0, 3))
        0: en = '0;
        1: en = 24'(1) << $urandom_range(0, 23);
        default: en = 24'($urandom);
      endcase
      stb = $urandom_range(0, 7) == 0;
      rdy = $urandom_range(0, 9) < 7;
      clr = $urandom_range(0, 49) == 0;
      tick();
    end
    stb = 0;
    clr = 0;
    drain_all();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/cic3_row_readout_sequencer.md
Name: cic3_row_readout_sequencer

Overview:
- Sequences readout of the 2x12 CIC3 filter row onto one narrow valid/ready stream.
- On each decimated-sample strobe, snapshots all 24 x 25-bit filter outputs into a shadow register.
- Drains the enabled channels one word per handshake, tagged with channel and frame number.
- Sits between the filter row output bus and the downstream readout FIFO/serializer; reports overruns when a strobe arrives before the previous frame has drained.

Parameters:
- NUM_CHANNELS, 24, filters in the row; bus layout is channel k at bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]. Channels 0-11 are the right subsection, 12-23 the left.
- DATA_WIDTH, 25, bits per filter output.
- CHAN_W, 5, channel tag width; must satisfy 2^CHAN_W >= NUM_CHANNELS.
- FRAME_W, 8, frame counter width.
- OVR_W, 8, overrun counter width.

Ports:
- clk  in  1  Modulator-rate clock; all logic on rising edge.
- reset  in  1  Asynchronous, active-high reset.
- filter_out  in  NUM_CHANNELS*DATA_WIDTH  Row output bus; must be stable in the strobe cycle.
- sample_strobe  in  1  One-clk pulse marking a new decimated sample, synchronous to clk.
- chan_enable  in  NUM_CHANNELS  Per-channel readout enable; sampled only at snapshot.
- clear_status  in  1  One-clk pulse; clears overrun_flag and overrun_cnt.
- dout_data  out  DATA_WIDTH  Snapshot word of the current channel.
- dout_chan  out  CHAN_W  Index of the current channel.
- dout_frame  out  FRAME_W  Frame number of the current snapshot.
- dout_last  out  1  High with the final enabled channel of the frame.
- dout_valid  out  1  Word available.
- dout_ready  in  1  Downstream accepts the word.
- busy  out  1  High while in DRAIN.
- overrun_flag  out  1  Sticky; set when a strobe is dropped.
- overrun_cnt  out  OVR_W  Count of dropped strobes; saturates at all-ones.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-drain):
  - All outputs 0; dout_valid drops at once.
  - State IDLE; frame counter 0; shadow register and latched mask 0.
- FSM has two states, IDLE and DRAIN.
- IDLE:
  - On sample_strobe with chan_enable != 0, latch filter_out and chan_enable, latch the current frame counter, then increment the counter (wraps at 2^FRAME_W-1 -> 0).
  - Next cycle, go to DRAIN with the cursor at the lowest enabled channel.
  - On sample_strobe with chan_enable == 0, ignore the strobe: no snapshot, no frame increment, no overrun.
- DRAIN:
  - dout_valid = 1. dout_data, dout_chan and dout_frame come from the shadow register and cursor.
  - All outputs hold stable while dout_ready = 0.
  - On handshake (valid & ready) of a non-last word, the cursor advances to the next-higher enabled channel in one cycle. There are no bubbles; disabled channels are skipped by a priority encoder.
  - dout_last = 1 exactly when no higher enabled channel exists.
  - On handshake of the last word, return to IDLE: dout_valid = 0 next cycle, unless a strobe is accepted (see below).
- Latency: strobe in cycle N gives dout_valid = 1 in cycle N+1, carrying the first enabled channel. With ready held high, an M-channel frame occupies cycles N+1 .. N+M.
- Strobe during DRAIN:
  - If it coincides with the last-word handshake, the strobe is accepted as a new snapshot. The FSM stays in DRAIN, dout_valid stays high, and the next cycle presents the new frame's first channel. No overrun is recorded.
  - Otherwise the strobe is dropped. The snapshot is unchanged, overrun_flag is set, and overrun_cnt increments, saturating at all-ones. The frame counter does not increment.
- clear_status takes priority over a same-cycle overrun: the flag and counter are 0 the next cycle.
- chan_enable changes during DRAIN have no effect until the next snapshot.
- busy = (state == DRAIN).

Test Plan:
- All channels enabled, ready held 1, filter_out channel k = k*1000, strobe at cycle 10:
  - Response: valid in cycles 11-34, chan 0..23, data k*1000, frame 0, last only at chan 23, busy low at cycle 35.
- chan_enable = 0x000801 (channels 0 and 11):
  - Response: exactly two words, chan 0 then chan 11 in consecutive cycles, last with chan 11.
- Ready toggled 1,0,0,1 pattern:
  - Response: data, chan and last hold stable through stalls; no word lost or duplicated.
- Second strobe mid-drain:
  - Response: overrun_flag = 1, overrun_cnt = 1, current frame completes unchanged.
  - Then a strobe coincident with the last handshake gives frame 1, first word in the next cycle, with no overrun.
- 300 overrun strobes, then clear_status asserted together with another overrun:
  - Response: cnt saturates at 255, then reads 0 and flag 0.
- Reset asserted mid-drain (cycle 15) for 1 cycle, then chan_enable = 0 with a strobe:
  - Response: valid drops asynchronously, frame counter returns to 0; the strobe is ignored and busy stays 0.
